gpio_irq_ctrl: RTL

- Input-side GPIO interrupt controller for the slurm16 SoC.
- Synchronises and glitch-filters the raw gpio_in pins and detects per-pin rising/falling edges into W1C pending bits.
- Raises a single level interrupt request to the CPU interrupt input when any unmasked pending bit is set.
- Register-mapped on the peripheral bus, sitting between the gpio_in pads and the CPU interrupt line.

---
 rtl/gpio_irq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gpio_irq_ctrl.sv
// GPIO input interrupt controller: per-pin synchroniser, glitch filter,
// rise/fall edge detection into W1C pending bits, masked level irq output.
module gpio_irq_ctrl #(
    parameter int unsigned NUM_PINS      = 6,
    parameter int unsigned FILTER_CYCLES = 2,
    parameter int unsigned FILTER_BITS   = 4
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic [NUM_PINS-1:0] gpio_in,
    input  logic [2:0]          ADDRESS,
    input  logic [15:0]         DATA_IN,
    output logic [15:0]         DATA_OUT,
    input  logic                VALID,
    input  logic                WR,
    output logic                irq
);

    localparam int unsigned N     = NUM_PINS;
    localparam int unsigned FB    = FILTER_BITS;
    localparam int unsigned REG_W = 16;

    // Bits above the implemented pins are held at zero in every register.
    localparam logic [REG_W-1:0] PIN_MASK = REG_W'((32'd1 << N) - 32'd1);

    localparam logic [2:0] ADDR_LEVEL   = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_FALL_EN = 3'd2;
    localparam logic [2:0] ADDR_PENDING = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_RAW     = 3'd5;

    logic [N-1:0]      s1_q, s1_d, s2_q, s2_d;
    logic [N-1:0]      filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic [FB-1:0]     cnt_q [N];
    logic [FB-1:0]     cnt_d [N];
    logic [FB-1:0]     cnt_nxt;
    logic [REG_W-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [REG_W-1:0]  pend_q, pend_d, mask_q, mask_d;
    logic [REG_W-1:0]  rd_data_q, rd_data_d, data_out_q, data_out_d;
    logic              rd_vld_q, rd_vld_d, irq_q, irq_d;
    logic [REG_W-1:0]  wdata, rd_val, rise_ev, fall_ev, clr_bits;
    logic              wr_req, rd_req;

    assign DATA_OUT = data_out_q;
    assign irq      = irq_q;

    // Next-state logic: sync, filter, edge detect, register file, read path.
    always_comb begin
        s1_d        = gpio_in;
        s2_d        = s1_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        cnt_d       = cnt_q;
        cnt_nxt     = '0;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        mask_d      = mask_q;
        rd_val      = '0;
        clr_bits    = '0;

        wr_req = VALID & WR;
        rd_req = VALID & ~WR;
        wdata  = DATA_IN & PIN_MASK;

        for (int i = 0; i < int'(N); i++) begin
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (FILTER_CYCLES == 0) begin
                filt_d[i] = s2_q[i];
            end else begin
                cnt_nxt = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + FB'(1);
                if (cnt_nxt == FB'(FILTER_CYCLES)) begin
                    filt_d[i] = s2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_nxt;
                end
            end
        end

        rise_ev = REG_W'(filt_q & ~filt_prev_q) & rise_en_q;
        fall_ev = REG_W'(~filt_q & filt_prev_q) & fall_en_q;

        if (wr_req) begin
            case (ADDRESS)
                ADDR_RISE_EN: rise_en_d = wdata;
                ADDR_FALL_EN: fall_en_d = wdata;
                ADDR_PENDING: clr_bits  = wdata;
                ADDR_MASK:    mask_d    = wdata;
                default:      ;
            endcase
        end

        // A new event wins over a same-cycle clear of that bit.
        pend_d = (pend_q & ~clr_bits) | rise_ev | fall_ev;
        irq_d  = |(pend_q & mask_q);

        case (ADDRESS)
            ADDR_LEVEL:   rd_val = REG_W'(filt_q);
            ADDR_RISE_EN: rd_val = rise_en_q;
            ADDR_FALL_EN: rd_val = fall_en_q;
            ADDR_PENDING: rd_val = pend_q;
            ADDR_MASK:    rd_val = mask_q;
            ADDR_RAW:     rd_val = REG_W'(s2_q);
            default:      rd_val = '0;
        endcase

        rd_data_d  = rd_req ? rd_val : rd_data_q;
        rd_vld_d   = rd_req;
        data_out_d = rd_vld_q ? rd_data_q : data_out_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            s1_q        <= '0;
            s2_q        <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            data_out_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_d[i];
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            data_out_q  <= data_out_d;
            irq_q       <= irq_d;
        end
    end

endmodule
